// File: rtl/memory_access_stage_if.sv
// Data-bus handshake between the MEM stage (master) and data memory (slave).
interface memory_access_stage_if #(
  parameter int WORD_LENGTH = 32
);
  logic                     req;
  logic                     we;
  logic [WORD_LENGTH-1:0]   addr;
  logic [WORD_LENGTH-1:0]   wdata;
  logic [WORD_LENGTH/8-1:0] strb;
  logic                     ack;
  logic [WORD_LENGTH-1:0]   rdata;

  modport master (output req, we, addr, wdata, strb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, strb, output ack, rdata);
endinterface

// File: rtl/memory_access_stage.sv
// RV32I MEM stage: turns EX/MEM load/store controls into a req/ack bus access and loads MEM/WB.
// state | meaning
// IDLE  | no access outstanding; ALU results pass to MEM/WB, new accesses accepted when en=1
// BUSY  | request held on the bus until ack or timeout
module memory_access_stage #(
  parameter int WORD_LENGTH        = 32,
  parameter int ADDRESS_PORT_WIDTH = 5,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WORD_LENGTH-1:0]        alu_result,
  input  logic [WORD_LENGTH-1:0]        read_data2,
  input  logic [2:0]                    func3,
  input  logic                          mem_write,
  input  logic                          mem_to_reg,
  input  logic                          reg_write,
  input  logic [ADDRESS_PORT_WIDTH-1:0] write_address,
  memory_access_stage_if.master         dbus,
  output logic                          stall,
  output logic                          misaligned_fault,
  output logic                          bus_fault,
  output logic [WORD_LENGTH-1:0]        mem_wb_alu_result,
  output logic [WORD_LENGTH-1:0]        mem_wb_read_data,
  output logic [ADDRESS_PORT_WIDTH-1:0] mem_wb_write_address,
  output logic                          mem_wb_reg_write,
  output logic                          mem_wb_mem_to_reg
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                          state;
  logic [CW-1:0]                   cnt;
  logic [WORD_LENGTH-1:0]          addr_q;
  logic [2:0]                      f3_q;
  logic [ADDRESS_PORT_WIDTH-1:0]   rd_q;
  logic                            rw_q;
  logic                            m2r_q;

  logic                   access, illegal, misaligned, start;
  logic [1:0]             size;
  logic [3:0]             strb_n;
  logic [WORD_LENGTH-1:0] wdata_n;
  logic [WORD_LENGTH-1:0] load_val;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;

  always_comb begin
    access     = mem_write | mem_to_reg;
    size       = func3[1:0];
    illegal    = mem_write ? (func3 > 3'b010)
                           : (func3 == 3'b011 || func3[2:1] == 2'b11);
    misaligned = (size == 2'b01 && alu_result[0]) ||
                 (size == 2'b10 && alu_result[1:0] != 2'b00);
    start      = (state == IDLE) && en && access && !illegal && !misaligned;
    // Reset must drop the freeze request immediately, not at the next edge.
    stall      = !rst && (start || (state == BUSY && !dbus.ack));

    case (size)
      2'b00:   begin strb_n = 4'b0001 << alu_result[1:0]; wdata_n = {4{read_data2[7:0]}};  end
      2'b01:   begin strb_n = 4'b0011 << alu_result[1:0]; wdata_n = {2{read_data2[15:0]}}; end
      default: begin strb_n = 4'b1111;                    wdata_n = read_data2;            end
    endcase

    lane_b = dbus.rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = dbus.rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = dbus.rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      dbus.req             <= 1'b0;
      dbus.we              <= 1'b0;
      dbus.addr            <= '0;
      dbus.wdata           <= '0;
      dbus.strb            <= '0;
      addr_q               <= '0;
      f3_q                 <= '0;
      rd_q                 <= '0;
      rw_q                 <= 1'b0;
      m2r_q                <= 1'b0;
      misaligned_fault     <= 1'b0;
      bus_fault            <= 1'b0;
      mem_wb_alu_result    <= '0;
      mem_wb_read_data     <= '0;
      mem_wb_write_address <= '0;
      mem_wb_reg_write     <= 1'b0;
      mem_wb_mem_to_reg    <= 1'b0;
    end else begin
      misaligned_fault <= 1'b0;
      bus_fault        <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            if (!access) begin
              mem_wb_alu_result    <= alu_result;
              mem_wb_read_data     <= '0;
              mem_wb_write_address <= write_address;
              mem_wb_reg_write     <= reg_write;
              mem_wb_mem_to_reg    <= mem_to_reg;
            end else if (illegal || misaligned) begin
              misaligned_fault     <= 1'b1;
              mem_wb_alu_result    <= '0;
              mem_wb_read_data     <= '0;
              mem_wb_write_address <= '0;
              mem_wb_reg_write     <= 1'b0;
              mem_wb_mem_to_reg    <= 1'b0;
            end else begin
              state      <= BUSY;
              dbus.req   <= 1'b1;
              dbus.we    <= mem_write;
              dbus.addr  <= {alu_result[WORD_LENGTH-1:2], 2'b00};
              dbus.wdata <= wdata_n;
              dbus.strb  <= strb_n;
              addr_q     <= alu_result;
              f3_q       <= func3;
              rd_q       <= write_address;
              rw_q       <= reg_write;
              m2r_q      <= mem_to_reg & ~mem_write;
            end
          end
        end
        BUSY: begin
          // Ack is tested first so a completion on the timeout cycle still succeeds.
          if (dbus.ack) begin
            state                <= IDLE;
            dbus.req             <= 1'b0;
            mem_wb_alu_result    <= addr_q;
            mem_wb_read_data     <= dbus.we ? '0 : load_val;
            mem_wb_write_address <= rd_q;
            mem_wb_reg_write     <= rw_q;
            mem_wb_mem_to_reg    <= m2r_q;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state                <= IDLE;
            dbus.req             <= 1'b0;
            bus_fault            <= 1'b1;
            mem_wb_alu_result    <= '0;
            mem_wb_read_data     <= '0;
            mem_wb_write_address <= '0;
            mem_wb_reg_write     <= 1'b0;
            mem_wb_mem_to_reg    <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: vector table, corner sequences, random vs. reference model.
module tb_memory_access_stage;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] alu_result, read_data2;
  logic [2:0]  func3;
  logic        mem_write, mem_to_reg, reg_write;
  logic [4:0]  write_address;

  logic        stall, mf, bf, wb_rw, wb_m2r;
  logic [31:0] wb_alu, wb_rd;
  logic [4:0]  wb_wa;
  logic        stall4, mf4, bf4, wb_rw4, wb_m2r4;
  logic [31:0] wb_alu4, wb_rd4;
  logic [4:0]  wb_wa4;

  memory_access_stage_if bus ();
  memory_access_stage_if bus4 ();

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .rst(rst), .en(en), .alu_result(alu_result), .read_data2(read_data2),
    .func3(func3), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .write_address(write_address), .dbus(bus), .stall(stall), .misaligned_fault(mf),
    .bus_fault(bf), .mem_wb_alu_result(wb_alu), .mem_wb_read_data(wb_rd),
    .mem_wb_write_address(wb_wa), .mem_wb_reg_write(wb_rw), .mem_wb_mem_to_reg(wb_m2r));

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .alu_result(alu_result), .read_data2(read_data2),
    .func3(func3), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .write_address(write_address), .dbus(bus4), .stall(stall4), .misaligned_fault(mf4),
    .bus_fault(bf4), .mem_wb_alu_result(wb_alu4), .mem_wb_read_data(wb_rd4),
    .mem_wb_write_address(wb_wa4), .mem_wb_reg_write(wb_rw4), .mem_wb_mem_to_reg(wb_m2r4));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access rules expressed with plain arithmetic.
  function automatic int unsigned nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f);
    if (st) return f <= 3'd2;
    return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit m_ok(input bit st, input logic [2:0] f, input logic [31:0] a);
    return m_legal(st, f) && ((a % nbytes(f)) == 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(f)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
    case (nbytes(f))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
    int unsigned     n;
    longint unsigned v;
    n = nbytes(f);
    if (n == 4) return r;
    v = {32'd0, r};
    v = (v >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (f[2] == 1'b0 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    en = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    func3 = 3'd0; alu_result = '0; read_data2 = '0; write_address = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [4:0] rd, input bit rw, input string tag);
    idle_inputs();
    alu_result = a; write_address = rd; reg_write = rw;
    @(posedge clk); #1;
    chk({tag, "_alu"}, wb_alu, a);
    chk({tag, "_rdata"}, wb_rd, 32'd0);
    chk({tag, "_wa"}, {27'd0, wb_wa}, {27'd0, rd});
    chk({tag, "_rw"}, {31'd0, wb_rw}, {31'd0, rw});
    chk({tag, "_m2r"}, {31'd0, wb_m2r}, 32'd0);
    idle_inputs();
  endtask

  // Runs one load/store from IDLE; called just after a rising edge.
  task automatic bus_op(input bit st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] r, input logic [4:0] rd, input int delay, input bit ok,
                        input logic [3:0] e_strb, input logic [31:0] e_wdata, input logic [31:0] e_rd,
                        input string tag);
    int stalls;
    en = 1'b1; mem_write = st; mem_to_reg = !st; reg_write = !st;
    func3 = f; alu_result = a; read_data2 = d; write_address = rd;
    #1 chk({tag, "_stall0"}, {31'd0, stall}, {31'd0, ok});
    stalls = stall ? 1 : 0;
    @(posedge clk); #1;
    if (!ok) begin
      chk({tag, "_mfault"}, {31'd0, mf}, 32'd1);
      chk({tag, "_noreq"}, {31'd0, bus.req}, 32'd0);
      chk({tag, "_bub_rw"}, {31'd0, wb_rw}, 32'd0);
      chk({tag, "_bub_m2r"}, {31'd0, wb_m2r}, 32'd0);
      idle_inputs();
      @(posedge clk); #1;
      chk({tag, "_mfault_pulse"}, {31'd0, mf}, 32'd0);
      return;
    end
    chk({tag, "_req"}, {31'd0, bus.req}, 32'd1);
    chk({tag, "_we"}, {31'd0, bus.we}, {31'd0, st});
    chk({tag, "_addr"}, bus.addr, a & 32'hFFFF_FFFC);
    chk({tag, "_strb"}, {28'd0, bus.strb}, {28'd0, e_strb});
    if (st) chk({tag, "_wdata"}, bus.wdata, e_wdata);
    for (int i = 0; i < delay; i++) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      chk({tag, "_addr_stable"}, bus.addr, a & 32'hFFFF_FFFC);
    end
    chk({tag, "_req_held"}, {31'd0, bus.req}, 32'd1);
    chk({tag, "_strb_stable"}, {28'd0, bus.strb}, {28'd0, e_strb});
    bus.ack = 1'b1; bus.rdata = r;
    #1 chk({tag, "_stall_ack"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    bus.ack = 1'b0; bus.rdata = $urandom;
    idle_inputs();
    chk({tag, "_stall_cycles"}, stalls, 1 + delay);
    chk({tag, "_req_drop"}, {31'd0, bus.req}, 32'd0);
    chk({tag, "_wb_rdata"}, wb_rd, st ? 32'd0 : e_rd);
    chk({tag, "_wb_alu"}, wb_alu, a);
    chk({tag, "_wb_wa"}, {27'd0, wb_wa}, {27'd0, rd});
    chk({tag, "_wb_rw"}, {31'd0, wb_rw}, {31'd0, !st});
    chk({tag, "_wb_m2r"}, {31'd0, wb_m2r}, {31'd0, !st});
    chk({tag, "_no_bfault"}, {31'd0, bf}, 32'd0);
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f;
    logic [31:0] a, d, r;
    int          delay;
    bit          ok;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //         st f     addr          data          rdata        dly ok strb     wdata         rd
    vecs[0]  = '{0, 3'd0, 32'h103,     32'h0,        32'h80FF1234, 1, 1, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[1]  = '{1, 3'd1, 32'h202,     32'h0000ABCD, 32'h0,        0, 1, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[2]  = '{0, 3'd5, 32'h2,       32'h0,        32'h80010000, 5, 1, 4'b1100, 32'h0,        32'h00008001};
    vecs[3]  = '{0, 3'd2, 32'h101,     32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{1, 3'd2, 32'h3,       32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{0, 3'd1, 32'h0,       32'h0,        32'h12348765, 2, 1, 4'b0011, 32'h0,        32'hFFFF8765};
    vecs[6]  = '{1, 3'd0, 32'h11,      32'h123456A5, 32'h0,        1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{0, 3'd4, 32'h2,       32'h0,        32'h11C32233, 0, 1, 4'b0100, 32'h0,        32'h000000C3};
    vecs[8]  = '{0, 3'd2, 32'h44,      32'h0,        32'hDEADBEEF, 3, 1, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[9]  = '{0, 3'd3, 32'h0,       32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1, 3'd4, 32'h0,       32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1, 3'd2, 32'h8,       32'hCAFEF00D, 32'h0,        0, 1, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[12] = '{0, 3'd0, 32'h1,       32'h0,        32'h00007F00, 1, 1, 4'b0010, 32'h0,        32'h0000007F};

    bus.ack = 1'b0; bus.rdata = '0; bus4.ack = 1'b0; bus4.rdata = '0;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    chk("rst_wb_rw", {31'd0, wb_rw}, 32'd0);
    chk("rst_faults", {30'd0, mf, bf}, 32'd0);
    rst = 1'b0;

    alu_op(32'h0000_1234, 5'd4, 1'b1, "alu_first");

    for (int i = 0; i < 13; i++)
      bus_op(vecs[i].st, vecs[i].f, vecs[i].a, vecs[i].d, vecs[i].r, 5'(i + 1), vecs[i].delay,
             vecs[i].ok, vecs[i].e_strb, vecs[i].e_wdata, vecs[i].e_rd, $sformatf("vec%0d", i));

    // Ack while IDLE is ignored.
    alu_op(32'h0000_0ABC, 5'd6, 1'b1, "pre_idle_ack");
    bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk("idle_ack_req", {31'd0, bus.req}, 32'd0);
    chk("idle_ack_rdata", wb_rd, 32'd0);

    // en=0 in IDLE: no accept, MEM/WB held.
    alu_op(32'h0000_0099, 5'd9, 1'b1, "pre_en0");
    en = 1'b0; mem_to_reg = 1'b1; reg_write = 1'b1; func3 = 3'd2; alu_result = 32'h40;
    #1 chk("en0_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("en0_noreq", {31'd0, bus.req}, 32'd0);
    chk("en0_hold_alu", wb_alu, 32'h99);
    chk("en0_hold_wa", {27'd0, wb_wa}, 32'd9);
    idle_inputs();

    // Reset mid-BUSY.
    alu_op(32'h0000_0055, 5'd7, 1'b1, "pre_rst");
    mem_to_reg = 1'b1; reg_write = 1'b1; func3 = 3'd2; alu_result = 32'h20; write_address = 5'd8;
    @(posedge clk); #1;
    chk("rstbusy_req_before", {31'd0, bus.req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstbusy_req", {31'd0, bus.req}, 32'd0);
    chk("rstbusy_stall", {31'd0, stall}, 32'd0);
    chk("rstbusy_wb_alu", wb_alu, 32'd0);
    chk("rstbusy_wb_wa", {27'd0, wb_wa}, 32'd0);
    chk("rstbusy_wb_rw", {31'd0, wb_rw}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    alu_op(32'h0000_0077, 5'd3, 1'b1, "post_rst");

    // Timeout on the TIMEOUT_CYCLES=4 instance.
    do_reset();
    mem_write = 1'b1; func3 = 3'd2; alu_result = 32'h40; read_data2 = 32'h1111_2222;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_req_c%0d", k), {31'd0, bus4.req}, 32'd1);
      chk($sformatf("to_stall_c%0d", k), {31'd0, stall4}, 32'd1);
      chk($sformatf("to_nofault_c%0d", k), {31'd0, bf4}, 32'd0);
      @(posedge clk); #1;
    end
    chk("to_req_drop", {31'd0, bus4.req}, 32'd0);
    chk("to_bfault", {31'd0, bf4}, 32'd1);
    chk("to_stall_idle", {31'd0, stall4}, 32'd0);
    chk("to_bubble_rw", {31'd0, wb_rw4}, 32'd0);
    @(posedge clk); #1;
    chk("to_bfault_pulse", {31'd0, bf4}, 32'd0);

    // Ack on the last allowed cycle wins over the timeout.
    do_reset();
    mem_to_reg = 1'b1; reg_write = 1'b1; func3 = 3'd2; alu_result = 32'h80; write_address = 5'd12;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    bus4.ack = 1'b1; bus4.rdata = 32'h1234_5678;
    #1 chk("ackwin_stall", {31'd0, stall4}, 32'd0);
    @(posedge clk); #1;
    bus4.ack = 1'b0;
    idle_inputs();
    chk("ackwin_nofault", {31'd0, bf4}, 32'd0);
    chk("ackwin_req", {31'd0, bus4.req}, 32'd0);
    chk("ackwin_rdata", wb_rd4, 32'h1234_5678);
    chk("ackwin_rw", {31'd0, wb_rw4}, 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      bit          st;
      logic [2:0]  f;
      logic [31:0] a, d, r;
      int          dly;
      if ($urandom_range(0, 3) == 0) begin
        alu_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      end else begin
        st  = 1'($urandom_range(0, 1));
        f   = 3'($urandom_range(0, 7));
        a   = $urandom;
        d   = $urandom;
        r   = $urandom;
        dly = $urandom_range(0, 3);
        bus_op(st, f, a, d, r, 5'($urandom_range(0, 31)), dly, m_ok(st, f, a),
               m_strb(f, a), m_wdata(f, d), m_load(f, a, r), $sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
